// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: state encoding,
// opcode field location and the halt opcode.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned     OPCODE_MSB       = 23;
  localparam int unsigned     OPCODE_LSB       = 20;
  localparam logic [3:0]      OP_HALT          = 4'hF;
  localparam logic [15:0]     DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Load captures a new instruction and marks it valid;
// clear inserts a bubble (valid drops, payload kept); otherwise everything holds.
module ifid_reg #(
  parameter int WIDTH            = 16,
  parameter int INSTRUCTIONWIDTH = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic                        clear_i,
  input  logic [INSTRUCTIONWIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0]            pc_i,
  output logic                        valid_o,
  output logic [INSTRUCTIONWIDTH-1:0] instr_o,
  output logic [WIDTH-1:0]            pc_o
);

  logic                        valid_q;
  logic [INSTRUCTIONWIDTH-1:0] instr_q;
  logic [WIDTH-1:0]            pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// and fills the IF/ID register. Optional halt opcode enabled by FETCH_HALT_EN.
//
// Handshake: stall=1 means decode cannot accept; PC and IF/ID hold. A redirect
// always wins over stall and leaves a one-cycle bubble in IF/ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH            = 16,
  parameter int               INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0] RESET_PC         = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [WIDTH-1:0]            redirect_pc,
  output logic [WIDTH-1:0]            imem_addr,
  input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
  output logic                        ifid_valid,
  output logic [INSTRUCTIONWIDTH-1:0] ifid_instr,
  output logic [WIDTH-1:0]            ifid_pc,
  output logic                        halted,
  output logic [31:0]                 fetch_count,
  output logic [1:0]                  dbg_state_o
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      count_q, count_d;
  logic             load, clear;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    load    = 1'b0;
    clear   = 1'b0;
`ifdef FETCH_HALT_EN
    halted_d = halted_q;
`endif
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          clear = 1'b1;
        end else if (!stall) begin
          load    = 1'b1;
          pc_d    = pc_q + WIDTH'(1);
          count_d = count_q + 32'd1;
`ifdef FETCH_HALT_EN
          // The halt instruction itself still flows to decode.
          if (imem_rdata[OPCODE_MSB:OPCODE_LSB] == OP_HALT) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
`endif
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          clear   = 1'b1;
          state_d = FETCH;
`ifdef FETCH_HALT_EN
          halted_d = 1'b0;
`endif
        end else if (!stall) begin
          clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  ifid_reg #(
    .WIDTH            (WIDTH),
    .INSTRUCTIONWIDTH (INSTRUCTIONWIDTH)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .clear_i (clear),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .pc_o    (ifid_pc)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect traffic, all compared against a cycle-level reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr;
  logic [23:0] imem_rdata;
  logic        ifid_valid;
  logic [23:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  logic [23:0] mem [0:65535];
  assign imem_rdata = mem[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 = waiting one cycle after reset, 1 = fetching, 2 = halted.
  int          m_phase;
  logic [15:0] m_pc;
  bit          m_valid;
  logic [23:0] m_instr;
  logic [15:0] m_ifpc;
  logic [31:0] m_count;
  bit          m_halted;

  task automatic model_reset();
    m_phase = 0; m_pc = 16'h0000; m_valid = 0; m_instr = '0;
    m_ifpc = '0; m_count = '0; m_halted = 0;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [15:0] rpc);
    logic [23:0] word;
    word = mem[m_pc];
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (rv) begin
        m_pc = rpc; m_valid = 0;
      end else if (!st) begin
        m_instr = word; m_ifpc = m_pc; m_valid = 1;
        m_pc = m_pc + 16'd1; m_count = m_count + 32'd1;
`ifdef FETCH_HALT_EN
        if (word[23:20] == 4'hF) begin m_phase = 2; m_halted = 1; end
`endif
      end
    end else begin
      if (rv) begin
        m_pc = rpc; m_valid = 0; m_halted = 0; m_phase = 1;
      end else if (!st) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".addr"},  imem_addr,   m_pc);
    check_eq({tag, ".valid"}, ifid_valid,  m_valid);
    check_eq({tag, ".instr"}, ifid_instr,  m_instr);
    check_eq({tag, ".ifpc"},  ifid_pc,     m_ifpc);
    check_eq({tag, ".halt"},  halted,      m_halted);
    check_eq({tag, ".count"}, fetch_count, m_count);
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic step(input string tag, input logic st, input logic rv, input logic [15:0] rpc);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    model_step(st, rv, rpc);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".addr"},  imem_addr,   16'h0000);
    check_eq({tag, ".valid"}, ifid_valid,  1'b0);
    check_eq({tag, ".instr"}, ifid_instr,  24'h0);
    check_eq({tag, ".ifpc"},  ifid_pc,     16'h0);
    check_eq({tag, ".halt"},  halted,      1'b0);
    check_eq({tag, ".count"}, fetch_count, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] w;
    for (int a = 0; a < 65536; a++) begin
      w = 24'($urandom);
      if (w[23:20] == 4'hF) w[23:20] = 4'hE;
      mem[a] = w;
    end
    for (int a = 0; a < 4; a++) mem[a] = 24'(a + 1);

    // Reset and free run
    #1 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("state_idle", dbg_state, IDLE);
    for (int i = 0; i < 4; i++) step("free", 1'b0, 1'b0, 16'h0);
    check_eq("free.pc2", ifid_pc, 16'd2);
    check_eq("free.instr2", ifid_instr, 24'h000003);
    check_eq("free.count3", fetch_count, 32'd3);

    // Stall holding PC=5
    step("pre", 1'b0, 1'b0, 16'h0);
    step("pre", 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 16'h0);
    check_eq("stall.addr5", imem_addr, 16'd5);
    check_eq("stall.count5", fetch_count, 32'd5);
    step("resume", 1'b0, 1'b0, 16'h0);
    check_eq("resume.pc5", ifid_pc, 16'd5);

    // Redirect overrides stall
    step("redir", 1'b1, 1'b1, 16'h0040);
    check_eq("redir.addr", imem_addr, 16'h0040);
    check_eq("redir.bubble", ifid_valid, 1'b0);
    step("redir_tgt", 1'b0, 1'b0, 16'h0);
    check_eq("redir_tgt.pc", ifid_pc, 16'h0040);

    // PC wrap
    step("wrap_redir", 1'b0, 1'b1, 16'hFFFF);
    step("wrap", 1'b0, 1'b0, 16'h0);
    check_eq("wrap.ifpc", ifid_pc, 16'hFFFF);
    check_eq("wrap.addr", imem_addr, 16'h0000);

`ifdef FETCH_HALT_EN
    mem[3] = 24'hF00000;
    step("h_redir", 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) step("h_run", 1'b0, 1'b0, 16'h0);
    check_eq("halt.flag", halted, 1'b1);
    check_eq("halt.ifpc", ifid_pc, 16'd3);
    check_eq("halt.valid", ifid_valid, 1'b1);
    step("h_hold", 1'b0, 1'b0, 16'h0);
    check_eq("halt.drop", ifid_valid, 1'b0);
    step("h_hold", 1'b0, 1'b0, 16'h0);
    check_eq("halt.frozen", imem_addr, 16'd4);
    step("h_exit", 1'b0, 1'b1, 16'h0000);
    check_eq("halt.cleared", halted, 1'b0);
    for (int i = 0; i < 32; i++) mem[$urandom_range(0, 63)] = {4'hF, 20'($urandom)};
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic st, rv;
      logic [15:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                        : 16'($urandom_range(0, 63));
      step("rand", st, rv, rpc);
    end

    // Asynchronous reset in the middle of a redirect
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h1234;
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0;
    model_reset();
    check_eq("post_rst.state", dbg_state, IDLE);
    step("post_rst", 1'b0, 1'b0, 16'h0);
    check_eq("post_rst.state2", dbg_state, FETCH);
    step("post_rst", 1'b0, 1'b0, 16'h0);
    check_eq("post_rst.ifpc0", ifid_pc, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
